// File: rtl/riscv_pkg.sv
// Shared RV32 core definitions used by the pipeline control blocks.
//   hz_state_t : sequencing states of the hazard controller
//   OP_LOAD    : major opcode of the load instructions
//   REG_ZERO   : architectural register x0 (never a real dependency)
package riscv_pkg;

   typedef enum logic [1:0] {
      RUN,
      LU_STALL,
      MEM_WAIT,
      FLUSH
   } hz_state_t;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the pipeline performance statistics.
// Ports:
//   clk  : clock
//   rst  : asynchronous, active-high clear
//   inc  : count this cycle
//   cnt  : current count, sticks at all-ones instead of wrapping
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (inc && (cnt != '1)) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the RV32 5-stage core. Produces the
// enable and squash controls of the PC, IF/ID and ID/EX registers from
// load-use hazards, EX-stage redirects and multi-cycle data accesses, and
// keeps saturating stall/flush cycle counters.
// Ports:
//   clk, rst                  : clock, asynchronous active-high reset
//   id_rs1/id_rs2             : source registers of the ID instruction
//   id_use_rs1/id_use_rs2     : ID instruction actually reads rs1/rs2
//   de_rd/de_wer/de_is_load   : destination, write enable, load flag in ID/EX
//   ex_redirect               : one-cycle taken branch/jump pulse from EX
//   dmem_req/dmem_ack         : outstanding data access / completion
//   pc_en/fd_en/de_en         : register load enables
//   fd_flush/de_flush         : IF/ID and ID/EX squash
//   stall_cnt/flush_cnt       : performance counters
module hazard_ctrl
   import riscv_pkg::*;
#(
   parameter int REDIRECT_BUBBLES = 2,
   parameter int CNT_W            = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic [4:0]       de_rd,
   input  logic             de_wer,
   input  logic             de_is_load,
   input  logic             ex_redirect,
   input  logic             dmem_req,
   input  logic             dmem_ack,
   output logic             pc_en,
   output logic             fd_en,
   output logic             de_en,
   output logic             fd_flush,
   output logic             de_flush,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam logic [2:0] BUB_LOAD = 3'(REDIRECT_BUBBLES - 1);

   hz_state_t  state_reg, state_next;
   logic [2:0] bubble_cnt_reg, bubble_cnt_next;
   logic       redirect_pend_reg, redirect_pend_next;

   logic mem_stall;
   logic lu_hit;

   assign mem_stall = dmem_req & ~dmem_ack;

   assign lu_hit = de_is_load & de_wer & (de_rd != REG_ZERO) &
                   ((id_use_rs1 & (id_rs1 == de_rd)) |
                    (id_use_rs2 & (id_rs2 == de_rd)));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg         <= RUN;
         bubble_cnt_reg    <= '0;
         redirect_pend_reg <= 1'b0;
      end else begin
         state_reg         <= state_next;
         bubble_cnt_reg    <= bubble_cnt_next;
         redirect_pend_reg <= redirect_pend_next;
      end
   end

   always_comb begin
      state_next         = state_reg;
      bubble_cnt_next    = bubble_cnt_reg;
      redirect_pend_next = redirect_pend_reg;
      pc_en              = 1'b1;
      fd_en              = 1'b1;
      de_en              = 1'b1;
      fd_flush           = 1'b0;
      de_flush           = 1'b0;

      case (state_reg)
         RUN: begin
            if (mem_stall) begin
               state_next = MEM_WAIT;
            end else if (ex_redirect) begin
               state_next      = FLUSH;
               bubble_cnt_next = BUB_LOAD;
            end else if (lu_hit) begin
               // Hold PC and IF/ID, let a bubble into ID/EX this very cycle.
               state_next = LU_STALL;
               pc_en      = 1'b0;
               fd_en      = 1'b0;
               de_flush   = 1'b1;
            end
         end

         LU_STALL: begin
            // The bubble has already been inserted; lu_hit is ignored here
            // so the same load/consumer pair cannot stall a second time.
            if (mem_stall) begin
               state_next = MEM_WAIT;
            end else if (ex_redirect) begin
               state_next      = FLUSH;
               bubble_cnt_next = BUB_LOAD;
            end else begin
               state_next = RUN;
            end
         end

         MEM_WAIT: begin
            pc_en = 1'b0;
            fd_en = 1'b0;
            de_en = 1'b0;
            if (dmem_ack) begin
               redirect_pend_next = 1'b0;
               if (redirect_pend_reg || ex_redirect) begin
                  state_next      = FLUSH;
                  bubble_cnt_next = BUB_LOAD;
               end else begin
                  state_next = RUN;
               end
            end else if (ex_redirect) begin
               redirect_pend_next = 1'b1;
            end
         end

         FLUSH: begin
            fd_flush = 1'b1;
            de_flush = 1'b1;
            if (mem_stall) begin
               pc_en = 1'b0;
               fd_en = 1'b0;
               de_en = 1'b0;
            end
            // A fresh redirect restarts the squash window even while frozen.
            if (ex_redirect) begin
               bubble_cnt_next = BUB_LOAD;
            end else if (!mem_stall) begin
               if (bubble_cnt_reg == 3'd0) begin
                  state_next = RUN;
               end else begin
                  bubble_cnt_next = bubble_cnt_reg - 3'd1;
               end
            end
         end

         default: begin
            state_next = RUN;
         end
      endcase

      // Reset holds the pipeline frozen with both squashes asserted.
      if (rst) begin
         pc_en    = 1'b0;
         fd_en    = 1'b0;
         de_en    = 1'b0;
         fd_flush = 1'b1;
         de_flush = 1'b1;
      end
   end

   // Counter 0: stall cycles, counter 1: flush cycles.
   logic [1:0]       cnt_inc;
   logic [CNT_W-1:0] cnt_val [2];

   assign cnt_inc[0] = (state_reg == LU_STALL) || (state_reg == MEM_WAIT);
   assign cnt_inc[1] = fd_flush | de_flush;

   for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      sat_counter #(.W(CNT_W)) u_cnt (
         .clk (clk),
         .rst (rst),
         .inc (cnt_inc[gi]),
         .cnt (cnt_val[gi])
      );
   end

   assign stall_cnt = cnt_val[0];
   assign flush_cnt = cnt_val[1];

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios followed by random stimulus,
// all checked against a behavioural model. A second instance with 4-bit
// counters runs on the same stimulus to exercise saturation.
module tb_hazard_ctrl;

   localparam int RB  = 2;
   localparam int CW  = 16;
   localparam int CWS = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [4:0] id_rs1 = '0, id_rs2 = '0, de_rd = '0;
   logic       id_use_rs1 = 0, id_use_rs2 = 0, de_wer = 0, de_is_load = 0;
   logic       ex_redirect = 0, dmem_req = 0, dmem_ack = 0;

   logic           pc_en, fd_en, de_en, fd_flush, de_flush;
   logic [CW-1:0]  stall_cnt, flush_cnt;
   logic           s_pc_en, s_fd_en, s_de_en, s_fd_flush, s_de_flush;
   logic [CWS-1:0] s_stall_cnt, s_flush_cnt;

   always #5 clk = ~clk;

   hazard_ctrl #(.REDIRECT_BUBBLES(RB), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .de_rd(de_rd),
      .de_wer(de_wer), .de_is_load(de_is_load), .ex_redirect(ex_redirect),
      .dmem_req(dmem_req), .dmem_ack(dmem_ack), .pc_en(pc_en), .fd_en(fd_en),
      .de_en(de_en), .fd_flush(fd_flush), .de_flush(de_flush),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   hazard_ctrl #(.REDIRECT_BUBBLES(RB), .CNT_W(CWS)) dut_sat (
      .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .de_rd(de_rd),
      .de_wer(de_wer), .de_is_load(de_is_load), .ex_redirect(ex_redirect),
      .dmem_req(dmem_req), .dmem_ack(dmem_ack), .pc_en(s_pc_en), .fd_en(s_fd_en),
      .de_en(s_de_en), .fd_flush(s_fd_flush), .de_flush(s_de_flush),
      .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Model: a pipeline that is either waiting on memory, squashing for a
   // number of remaining cycles, just recovered from a bubble, or free.
   bit m_wait, m_pend, m_lu_done;
   int m_left, m_scnt, m_fcnt;

   function automatic int sat(input int v, input int w);
      int lim = (1 << w) - 1;
      return (v > lim) ? lim : v;
   endfunction

   task automatic model_clear();
      m_wait = 0; m_pend = 0; m_lu_done = 0;
      m_left = 0; m_scnt = 0; m_fcnt = 0;
   endtask

   task automatic step(input bit [4:0] rs1, input bit [4:0] rs2, input bit u1, input bit u2,
                       input bit [4:0] rd, input bit wer, input bit ld,
                       input bit redir, input bit req, input bit ack);
      bit       lu, ms, was;
      bit [4:0] e;
      @(negedge clk);
      id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
      de_rd = rd; de_wer = wer; de_is_load = ld;
      ex_redirect = redir; dmem_req = req; dmem_ack = ack;
      #1;
      lu = ld && wer && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
      ms = req && !ack;
      if (m_wait)                                  e = 5'b00000;
      else if (m_left > 0)                         e = ms ? 5'b00011 : 5'b11111;
      else if (!ms && !redir && lu && !m_lu_done)  e = 5'b00101;
      else                                         e = 5'b11100;
      chk("outs",      {pc_en, fd_en, de_en, fd_flush, de_flush}, 32'(e));
      chk("outs_w4",   {s_pc_en, s_fd_en, s_de_en, s_fd_flush, s_de_flush}, 32'(e));
      chk("stall_cnt", 32'(stall_cnt), sat(m_scnt, CW));
      chk("flush_cnt", 32'(flush_cnt), sat(m_fcnt, CW));
      chk("stall_w4",  32'(s_stall_cnt), sat(m_scnt, CWS));
      chk("flush_w4",  32'(s_flush_cnt), sat(m_fcnt, CWS));
      $display("t=%0t lu=%0b redir=%0b req=%0b ack=%0b outs=%05b stall=%0d flush=%0d",
               $time, lu, redir, req, ack, {pc_en, fd_en, de_en, fd_flush, de_flush},
               stall_cnt, flush_cnt);
      // advance the model across the coming clock edge
      m_scnt += (m_wait || m_lu_done) ? 1 : 0;
      m_fcnt += (e[1] || e[0]) ? 1 : 0;
      if (m_wait) begin
         if (ack) begin
            m_wait = 0;
            if (m_pend || redir) m_left = RB;
            m_pend = 0;
         end else if (redir) begin
            m_pend = 1;
         end
      end else if (m_left > 0) begin
         if (redir)    m_left = RB;
         else if (!ms) m_left--;
      end else begin
         was = m_lu_done;
         m_lu_done = 0;
         if (ms)              m_wait = 1;
         else if (redir)      m_left = RB;
         else if (lu && !was) m_lu_done = 1;
      end
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Asynchronous reset asserted between edges, checked before any edge.
   task automatic do_reset();
      @(negedge clk);
      id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0; de_rd = 0;
      de_wer = 0; de_is_load = 0; ex_redirect = 0; dmem_req = 0; dmem_ack = 0;
      #2 rst = 1'b1;
      #1;
      chk("rst_outs",  {pc_en, fd_en, de_en, fd_flush, de_flush}, 32'b00011);
      chk("rst_stall", 32'(stall_cnt), 0);
      chk("rst_flush", 32'(flush_cnt), 0);
      $display("t=%0t reset asserted outs=%05b", $time, {pc_en, fd_en, de_en, fd_flush, de_flush});
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_clear();
   endtask

   initial begin
      model_clear();
      do_reset();

      // load-use on rs2: one bubble cycle, then no second stall
      step(0, 5, 0, 1, 5, 1, 1, 0, 0, 0);
      chk("lu_pc_en", 32'(pc_en), 0);
      step(0, 5, 0, 1, 5, 1, 1, 0, 0, 0);
      chk("lu_once", 32'(pc_en), 1);
      idle();
      chk("lu_stall_cnt", 32'(stall_cnt), 1);

      // x0 destination never stalls
      do_reset();
      step(0, 0, 0, 1, 0, 1, 1, 0, 0, 0);
      chk("lu_x0", 32'(pc_en), 1);

      // single redirect: two squash cycles
      do_reset();
      step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      idle(); idle(); idle();
      chk("redir_flush_cnt", 32'(flush_cnt), 2);

      // second pulse in the first squash cycle: three squash cycles
      do_reset();
      step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      idle(); idle(); idle();
      chk("redir2_flush_cnt", 32'(flush_cnt), 3);

      // memory wait: ack low 4 cycles
      do_reset();
      repeat (4) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      idle();
      chk("mem_stall_cnt", 32'(stall_cnt), 4);

      // load-use together with redirect: redirect wins
      do_reset();
      step(5, 0, 1, 0, 5, 1, 1, 1, 0, 0);
      chk("sim_no_bubble", 32'(pc_en), 1);
      idle();
      chk("sim_flush", 32'(fd_flush), 1);

      // redirect during memory wait: squash starts after the ack
      do_reset();
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      chk("memredir_wait", 32'(fd_flush), 0);
      idle();
      chk("memredir_flush", 32'(fd_flush), 1);

      // reset in the middle of a memory wait with a pending redirect
      do_reset();
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
      do_reset();
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      idle();
      chk("rst_drops_pend", 32'(fd_flush), 0);

      // saturation of the 4-bit instance
      do_reset();
      repeat (22) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      idle();
      chk("sat_w4", 32'(s_stall_cnt), 15);

      // random traffic
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         if (i % 400 == 399) do_reset();
         step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
